// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } uart_tx_state_t;

   localparam int unsigned UART_OVERSAMPLE   = 8;
   localparam int unsigned UART_OVERSAMPLE_W = $clog2(UART_OVERSAMPLE);
   localparam logic        UART_IDLE_LEVEL   = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Loadable down-counter marking the end of a bit period; shared by TX and RX.
module uart_baud_counter #(
   parameter int unsigned CNT_W = 19
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             tick_c,
   output logic             zero_next_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load wins over counting; counter parks at zero between frames.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_c      = (cnt_q == '0);
   assign zero_next_c = (cnt_d == '0);

endmodule

// File: rtl/uart_axis_tx.sv
// AXI-stream fed 8N1 UART transmitter with zero-gap back-to-back frames.
module uart_axis_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESC_W    = 16
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic [DATA_WIDTH-1:0] input_axis_tdata,
   input  logic                  input_axis_tvalid,
   output logic                  input_axis_tready,
   input  logic [PRESC_W-1:0]    prescale,
   output logic                  txd,
   output logic                  busy
);

   localparam int unsigned CNT_W = PRESC_W + UART_OVERSAMPLE_W;
   localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   uart_tx_state_t          state_q;
   uart_tx_state_t          state_d;
   logic [DATA_WIDTH-1:0]   shift_q;
   logic [DATA_WIDTH-1:0]   shift_d;
   logic [IDX_W-1:0]        idx_q;
   logic [IDX_W-1:0]        idx_d;
   logic [CNT_W-1:0]        period_q;
   logic [CNT_W-1:0]        period_d;
   logic [PRESC_W-1:0]      presc_eff_c;
   logic [CNT_W-1:0]        accept_period_c;
   logic                    accept_c;
   logic                    load_c;
   logic [CNT_W-1:0]        load_val_c;
   logic                    tick_c;
   logic                    zero_next_c;
   logic                    txd_d;
   logic                    busy_d;
   logic                    tready_d;

   // A zero prescale would give no bit period at all; run it as the fastest rate.
   assign presc_eff_c     = (prescale == '0) ? PRESC_W'(1) : prescale;
   assign accept_period_c = {presc_eff_c, UART_OVERSAMPLE_W'(0)};
   assign accept_c        = input_axis_tvalid & input_axis_tready;

   uart_baud_counter #(
      .CNT_W (CNT_W)
   ) u_baud (
      .clk         (clk),
      .nrst        (nrst),
      .load        (load_c),
      .load_val    (load_val_c),
      .tick_c      (tick_c),
      .zero_next_c (zero_next_c)
   );

   // Frame sequencing; every bit start reloads the baud counter with T-1.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      idx_d      = idx_q;
      period_d   = period_q;
      load_c     = 1'b0;
      load_val_c = period_q - CNT_W'(1);
      case (state_q)
         TX_IDLE: begin
            if (accept_c) begin
               state_d    = TX_START;
               shift_d    = input_axis_tdata;
               period_d   = accept_period_c;
               load_c     = 1'b1;
               load_val_c = accept_period_c - CNT_W'(1);
            end
         end
         TX_START: begin
            if (tick_c) begin
               state_d = TX_DATA;
               idx_d   = '0;
               load_c  = 1'b1;
            end
         end
         TX_DATA: begin
            if (tick_c) begin
               load_c  = 1'b1;
               shift_d = shift_q >> 1;
               if (idx_q == LAST_IDX) begin
                  state_d = TX_STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         TX_STOP: begin
            // tready is only high on the final stop cycle, so an accept here also ends the bit.
            if (accept_c) begin
               state_d    = TX_START;
               shift_d    = input_axis_tdata;
               period_d   = accept_period_c;
               load_c     = 1'b1;
               load_val_c = accept_period_c - CNT_W'(1);
            end else if (tick_c) begin
               state_d = TX_IDLE;
            end
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase
   end

   // Next values of the registered outputs, decoded from the next state.
   always_comb begin
      txd_d    = UART_IDLE_LEVEL;
      busy_d   = (state_d != TX_IDLE);
      tready_d = (state_d == TX_IDLE) || ((state_d == TX_STOP) && zero_next_c);
      case (state_d)
         TX_START: txd_d = ~UART_IDLE_LEVEL;
         TX_DATA:  txd_d = shift_d[0];
         default:  txd_d = UART_IDLE_LEVEL;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q           <= TX_IDLE;
         shift_q           <= '0;
         idx_q             <= '0;
         period_q          <= '0;
         txd               <= UART_IDLE_LEVEL;
         busy              <= 1'b0;
         input_axis_tready <= 1'b0;
      end else begin
         state_q           <= state_d;
         shift_q           <= shift_d;
         idx_q             <= idx_d;
         period_q          <= period_d;
         txd               <= txd_d;
         busy              <= busy_d;
         input_axis_tready <= tready_d;
      end
   end

endmodule

// File: tb/tb_uart_axis_tx.sv
// Directed and randomized frame checks for uart_axis_tx against a line-level model.
module tb_uart_axis_tx;

   localparam int unsigned DW = 8;
   localparam int unsigned PW = 16;

   logic          clk = 1'b0;
   logic          nrst;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tready;
   logic [PW-1:0] prescale;
   logic          txd;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_axis_tx #(
      .DATA_WIDTH (DW),
      .PRESC_W    (PW)
   ) dut (
      .clk               (clk),
      .nrst              (nrst),
      .input_axis_tdata  (tdata),
      .input_axis_tvalid (tvalid),
      .input_axis_tready (tready),
      .prescale          (prescale),
      .txd               (txd),
      .busy              (busy)
   );

   // Bit period in clocks for a given prescale value.
   function automatic int period(input logic [PW-1:0] p);
      return (p == '0) ? 8 : int'(p) * 8;
   endfunction

   // Expected line level c cycles into a frame: start bit, LSB-first data, stop bit.
   function automatic logic exp_txd(input logic [DW-1:0] d, input int t, input int c);
      int b;
      b = c / t;
      if (b == 0) return 1'b0;
      if (b <= int'(DW)) return d[b-1];
      return 1'b1;
   endfunction

   task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_txd"},    -1, 32'(txd),    32'd1);
      chk({tag, "_busy"},   -1, 32'(busy),   32'd0);
      chk({tag, "_tready"}, -1, 32'(tready), 32'd1);
   endtask

   // Caller has tvalid/tdata/prescale set with tready high; the accept edge happens here.
   // mode 0: idle producer with churning data, 1: hold next byte valid,
   // 2: pulse tvalid mid-frame then drop, 3: after-accept change to 0xEE / prescale 9.
   task automatic frame(input logic [DW-1:0] d, input int t, input int mode,
                        input logic [DW-1:0] nd, input logic [PW-1:0] np);
      int len;
      int pa;
      int pb;
      len = (int'(DW) + 2) * t;
      pa  = int'($urandom_range(len / 2, 1));
      pb  = pa + int'($urandom_range(len / 4, 0));
      step();
      for (int c = 0; c < len; c++) begin
         chk("txd",    c, 32'(txd),    32'(exp_txd(d, t, c)));
         chk("busy",   c, 32'(busy),   32'd1);
         chk("tready", c, 32'(tready), 32'(c == len - 1));
         case (mode)
            1: begin
               tvalid = 1'b1; tdata = nd; prescale = np;
            end
            2: begin
               tvalid = (c >= pa) && (c <= pb);
               tdata = DW'($urandom); prescale = PW'($urandom);
            end
            3: begin
               tvalid = 1'b0; tdata = 8'hEE; prescale = 16'd9;
            end
            default: begin
               tvalid = 1'b0; tdata = DW'($urandom); prescale = PW'($urandom);
            end
         endcase
         if (c < len - 1) step();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d;
      logic [DW-1:0] nd;
      logic [PW-1:0] p;
      logic [PW-1:0] np;
      int            m;

      nrst = 1'b0; tvalid = 1'b0; tdata = '0; prescale = '0;
      repeat (3) step();
      chk("rst_txd",    -1, 32'(txd),    32'd1);
      chk("rst_busy",   -1, 32'(busy),   32'd0);
      chk("rst_tready", -1, 32'(tready), 32'd0);
      #2 nrst = 1'b1;
      step();
      idle_chk("post_rst");

      // T1: 0x55 at prescale 4
      tvalid = 1'b1; tdata = 8'h55; prescale = 16'd4;
      frame(8'h55, 32, 0, 8'h00, 16'd0);
      step();
      idle_chk("t1_end");

      // T2: back-to-back 0xA5 then 0x3C
      tvalid = 1'b1; tdata = 8'hA5; prescale = 16'd4;
      frame(8'hA5, 32, 1, 8'h3C, 16'd4);
      frame(8'h3C, 32, 0, 8'h00, 16'd0);
      step();
      idle_chk("t2_end");

      // T6: tvalid pulsed while busy, dropped before the last stop cycle
      d = DW'($urandom);
      tvalid = 1'b1; tdata = d; prescale = 16'd2;
      frame(d, 16, 2, 8'h00, 16'd0);
      step();
      idle_chk("t6_end");
      step();
      idle_chk("t6_quiet");

      // T4: prescale 0 runs at T=8
      tvalid = 1'b1; tdata = 8'h81; prescale = 16'd0;
      frame(8'h81, 8, 0, 8'h00, 16'd0);
      step();
      idle_chk("t4_end");

      // T5: inputs change right after accept
      tvalid = 1'b1; tdata = 8'h12; prescale = 16'd4;
      frame(8'h12, 32, 3, 8'h00, 16'd0);
      step();
      idle_chk("t5_end");

      // T3: reset during data bit 3 of 0xFF, then a clean 0x00 frame
      tvalid = 1'b1; tdata = 8'hFF; prescale = 16'd2;
      step();
      tvalid = 1'b0;
      chk("t3_start", 0, 32'(txd), 32'd0);
      repeat (4 * 16 + 3) step();
      chk("t3_bit3_txd",  -1, 32'(txd),  32'd1);
      chk("t3_bit3_busy", -1, 32'(busy), 32'd1);
      #2 nrst = 1'b0;
      #1;
      chk("t3_async_txd",    -1, 32'(txd),    32'd1);
      chk("t3_async_busy",   -1, 32'(busy),   32'd0);
      chk("t3_async_tready", -1, 32'(tready), 32'd0);
      step();
      chk("t3_held_tready", -1, 32'(tready), 32'd0);
      #2 nrst = 1'b1;
      step();
      idle_chk("t3_release");
      tvalid = 1'b1; tdata = 8'h00; prescale = 16'd2;
      frame(8'h00, 16, 0, 8'h00, 16'd0);
      step();
      idle_chk("t3_end");

      // Randomized frames, mixing idle gaps, back-to-back and ignored pulses
      d = DW'($urandom);
      p = PW'($urandom_range(3, 0));
      tvalid = 1'b1; tdata = d; prescale = p;
      for (int i = 0; i < 12; i++) begin
         nd = DW'($urandom);
         np = PW'($urandom_range(3, 0));
         m  = (i == 11) ? 0 : int'($urandom_range(2, 0));
         frame(d, period(p), m, nd, np);
         if (m != 1) begin
            step();
            idle_chk("rand_idle");
            if (i < 11) begin
               tvalid = 1'b1; tdata = nd; prescale = np;
            end else begin
               tvalid = 1'b0;
            end
         end
         d = nd;
         p = np;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
